// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: drives the configuration flip-flop chain of an I/O tile
// column. A sync pattern is shifted in ahead of the payload. The pattern must
// leave ccff_tail after exactly CHAIN_LEN shifts, which proves the chain
// length and its integrity.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; shift_count holds the last load's value
// SYNC   | shifting SYNC_PATTERN MSB-first, one bit per cycle, no stalls
// LOAD   | shifting payload words from the buffer; stalls when it is empty
// CHECK  | one cycle: report done or error from the tail-compare flag
module ccff_chain_loader #(
  parameter int                CHAIN_LEN    = 20,
  parameter int                WORD_W       = 8,
  parameter int                SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
  localparam int               TOTAL        = SYNC_W + CHAIN_LEN,
  localparam int               CNT_W        = $clog2(TOTAL + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  shift_count
);

  localparam int BCNT_W = $clog2(WORD_W + 1);

  localparam logic [CNT_W-1:0]  TOTAL_C     = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0]  CHAIN_C     = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0]  SYNC_LAST_C = CNT_W'(SYNC_W - 1);
  localparam logic [BCNT_W-1:0] WORD_C      = BCNT_W'(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_LOAD  = 2'd2,
    S_CHECK = 2'd3
  } state_t;

  state_t              state;
  logic [SYNC_W-1:0]   sync_sr;   // pattern bits still to be shifted in
  logic [SYNC_W-1:0]   tail_sr;   // pattern bits still expected at the tail
  logic                mismatch;  // any tail bit differed during this load
  logic [WORD_W-1:0]   word_buf;
  logic [BCNT_W-1:0]   buf_cnt;   // valid bits left in word_buf, MSB-aligned
  logic                tail_check;

  // Buffer empty and payload still owed: the only time a word is taken.
  // Decoded purely from registers, so it never depends on data_valid.
  assign data_ready = (state == S_LOAD) && (buf_cnt == '0) && (shift_count != TOTAL_C);

  // The edge currently on ccff_shift_en is edge (shift_count-1). Edges at or
  // beyond CHAIN_LEN expose the sync bits at the tail, before the capture.
  assign tail_check = ccff_shift_en && (shift_count > CHAIN_C);

  // Sequencer, serializer and tail checker; all outputs are registered.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state         <= S_IDLE;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      shift_count   <= '0;
      sync_sr       <= '0;
      tail_sr       <= '0;
      mismatch      <= 1'b0;
      word_buf      <= '0;
      buf_cnt       <= '0;
    end else begin
      done <= 1'b0;

      if (tail_check) begin
        if (ccff_tail != tail_sr[SYNC_W-1]) begin
          mismatch <= 1'b1;
        end
        tail_sr <= tail_sr << 1;
      end

      case (state)
        S_IDLE: begin
          ccff_shift_en <= 1'b0;
          if (start) begin
            state       <= S_SYNC;
            busy        <= 1'b1;
            error       <= 1'b0;
            shift_count <= '0;
            mismatch    <= 1'b0;
            sync_sr     <= SYNC_PATTERN;
            tail_sr     <= SYNC_PATTERN;
            buf_cnt     <= '0;
          end
        end

        S_SYNC: begin
          ccff_head     <= sync_sr[SYNC_W-1];
          sync_sr       <= sync_sr << 1;
          ccff_shift_en <= 1'b1;
          shift_count   <= shift_count + 1'b1;
          if (shift_count == SYNC_LAST_C) begin
            state <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (shift_count == TOTAL_C) begin
            // Last edge is on the chain now; any unused low bits of the
            // final word are dropped with the buffer.
            ccff_shift_en <= 1'b0;
            buf_cnt       <= '0;
            state         <= S_CHECK;
          end else if (buf_cnt != '0) begin
            ccff_head     <= word_buf[WORD_W-1];
            word_buf      <= word_buf << 1;
            buf_cnt       <= buf_cnt - 1'b1;
            ccff_shift_en <= 1'b1;
            shift_count   <= shift_count + 1'b1;
          end else begin
            // Buffer empty: the chain holds until a word arrives.
            ccff_shift_en <= 1'b0;
            if (data_valid && data_ready) begin
              word_buf <= data_in;
              buf_cnt  <= WORD_C;
            end
          end
        end

        S_CHECK: begin
          ccff_shift_en <= 1'b0;
          ccff_head     <= 1'b0;
          busy          <= 1'b0;
          if (mismatch) begin
            error <= 1'b1;
          end else begin
            done <= 1'b1;
          end
          state <= S_IDLE;
        end

        default: begin
          state         <= S_IDLE;
          ccff_shift_en <= 1'b0;
          busy          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural shift-register chain, ready/valid
// host and a scoreboard of expected ccff_head bits per shift.
module tb_ccff_chain_loader;

  localparam int CHAIN_LEN = 20;
  localparam int WORD_W    = 8;
  localparam int SYNC_W    = 8;
  localparam int TOTAL     = SYNC_W + CHAIN_LEN;
  localparam int CNT_W     = $clog2(TOTAL + 1);

  logic              prog_clk = 1'b0;
  logic              prog_reset_n = 1'b0;
  logic              start = 1'b0;
  logic [WORD_W-1:0] data_in = '0;
  logic              data_valid = 1'b0;
  logic              data_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              error;
  logic [CNT_W-1:0]  shift_count;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [31:0] chain = '0;
  int          chain_len_m = 20;
  bit          tail_zero = 1'b0;

  logic [7:0] words[$];
  bit         exp_bits[$];
  int         gap_after = -1;
  int         gap_left = 0;
  bit         gap_prev = 1'b0;
  bit         error_q = 1'b0;

  int accepted_cnt = 0;
  int shift_cycles = 0;
  int done_cnt = 0;
  int payload_pushed = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int error_cyc = 0;
  int lat1 = 0;

  ccff_chain_loader dut (
    .prog_clk      (prog_clk),
    .prog_reset_n  (prog_reset_n),
    .start         (start),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .shift_count   (shift_count)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) cyc <= cyc + 1;

  // Behavioural ccff chain: newest bit at [0], tail at [chain_len_m-1].
  always @(posedge prog_clk) if (ccff_shift_en === 1'b1) chain <= {chain[30:0], ccff_head};
  assign ccff_tail = tail_zero ? 1'b0 : chain[chain_len_m-1];

  // Monitor (scoreboard pop) and host driver (scoreboard push), once per cycle.
  always @(negedge prog_clk) begin
    if (!prog_reset_n) begin
      data_valid = 1'b0;
      gap_prev   = 1'b0;
      error_q    = 1'b0;
    end else begin
      if (gap_prev) begin
        compared++;
        if (ccff_shift_en !== 1'b0) begin
          mismatched++;
          $display("FAIL stall_gap: ccff_shift_en=%b required 0 at cycle %0d", ccff_shift_en, cyc);
        end
      end
      gap_prev = 1'b0;

      if (ccff_shift_en === 1'b1) begin
        shift_cycles++;
        compared++;
        if (exp_bits.size() == 0) begin
          mismatched++;
          $display("FAIL head_extra: shift %0d with no expected bit", shift_cycles);
        end else begin
          bit e;
          e = exp_bits.pop_front();
          if (ccff_head !== e) begin
            mismatched++;
            $display("FAIL head_bit: shift %0d ccff_head=%b required %b", shift_cycles, ccff_head, e);
          end
        end
      end

      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end

      if (error === 1'b1 && !error_q) begin
        error_cyc = cyc;
        compared++;
        if (busy !== 1'b0) begin
          mismatched++;
          $display("FAIL busy_at_error: busy=%b required 0", busy);
        end
      end
      error_q = (error === 1'b1);

      if (words.size() > 0) begin
        if (data_ready === 1'b1 && accepted_cnt == gap_after && gap_left > 0) begin
          data_valid = 1'b0;
          gap_left--;
          gap_prev = 1'b1;
        end else begin
          data_valid = 1'b1;
          data_in    = words[0];
          if (data_ready === 1'b1) begin
            int n;
            n = CHAIN_LEN - payload_pushed;
            if (n > WORD_W) n = WORD_W;
            for (int i = 0; i < n; i++) exp_bits.push_back(words[0][WORD_W-1-i]);
            payload_pushed += n;
            accepted_cnt++;
            void'(words.pop_front());
          end
        end
      end else begin
        data_valid = 1'b0;
      end
    end
  end

  task automatic kick(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2);
    logic [7:0] sp;
    sp = 8'hA5;
    @(negedge prog_clk);
    words.delete();
    words.push_back(w0);
    words.push_back(w1);
    words.push_back(w2);
    exp_bits.delete();
    for (int i = 0; i < SYNC_W; i++) exp_bits.push_back(sp[SYNC_W-1-i]);
    accepted_cnt   = 0;
    shift_cycles   = 0;
    done_cnt       = 0;
    payload_pushed = 0;
    error_cyc      = -1;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge prog_clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge prog_clk);
      #1;
      if (done_cnt > 0 || error === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    prog_reset_n = 1'b0;
    repeat (3) @(negedge prog_clk);
    compared++;
    if ({data_ready, ccff_head, ccff_shift_en, busy, done, error} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: {rdy,head,sh,busy,done,err}=%b required 000000",
               {data_ready, ccff_head, ccff_shift_en, busy, done, error});
    end
    compared++;
    if (shift_count !== '0) begin
      mismatched++;
      $display("FAIL reset_count: shift_count=%0d required 0", shift_count);
    end
    prog_reset_n = 1'b1;
    repeat (2) @(negedge prog_clk);
  endtask

  task automatic test_basic();
    bit ok;
    chain_len_m = 20; tail_zero = 1'b0; gap_after = -1; gap_left = 0;
    kick(8'hC3, 8'h5A, 8'hF0);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy: busy=%b required 1", busy); end
    wait_end(200, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL basic_timeout: no done/error within 200 cycles"); end
    repeat (4) @(negedge prog_clk);
    #1;
    compared++;
    if (done_cnt != 1) begin mismatched++; $display("FAIL basic_done_cnt: %0d pulses required 1", done_cnt); end
    compared++;
    if (error !== 1'b0) begin mismatched++; $display("FAIL basic_error: error=%b required 0", error); end
    compared++;
    if (chain[19:0] !== 20'hC35AF) begin mismatched++; $display("FAIL basic_chain: %h required c35af", chain[19:0]); end
    compared++;
    if (accepted_cnt != 3) begin mismatched++; $display("FAIL basic_words: %0d accepted required 3", accepted_cnt); end
    compared++;
    if (shift_cycles != TOTAL) begin mismatched++; $display("FAIL basic_shifts: %0d required %0d", shift_cycles, TOTAL); end
    compared++;
    if (shift_count !== 5'd28) begin mismatched++; $display("FAIL basic_count: shift_count=%0d required 28", shift_count); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_idle_busy: busy=%b required 0", busy); end
    compared++;
    if (exp_bits.size() != 0) begin mismatched++; $display("FAIL basic_leftover: %0d bits unshifted required 0", exp_bits.size()); end
    lat1 = done_cyc - start_cyc;
  endtask

  task automatic test_stall();
    bit ok;
    chain_len_m = 20; tail_zero = 1'b0; gap_after = 1; gap_left = 5;
    kick(8'hC3, 8'h5A, 8'hF0);
    wait_end(200, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL stall_timeout: no done/error within 200 cycles"); end
    repeat (4) @(negedge prog_clk);
    #1;
    compared++;
    if (done_cnt != 1) begin mismatched++; $display("FAIL stall_done_cnt: %0d pulses required 1", done_cnt); end
    compared++;
    if (chain[19:0] !== 20'hC35AF) begin mismatched++; $display("FAIL stall_chain: %h required c35af", chain[19:0]); end
    compared++;
    if (shift_cycles != TOTAL) begin mismatched++; $display("FAIL stall_shifts: %0d required %0d", shift_cycles, TOTAL); end
    compared++;
    if (done_cyc - start_cyc != lat1 + 5) begin
      mismatched++;
      $display("FAIL stall_latency: %0d cycles required %0d", done_cyc - start_cyc, lat1 + 5);
    end
    compared++;
    if (gap_left != 0) begin mismatched++; $display("FAIL stall_gap_used: %0d gap cycles unused required 0", gap_left); end
    gap_after = -1;
  endtask

  task automatic test_short_chain();
    bit ok;
    chain_len_m = 19; tail_zero = 1'b0;
    kick(8'hC3, 8'h5A, 8'hF0);
    wait_end(200, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL short_timeout: no done/error within 200 cycles"); end
    repeat (4) @(negedge prog_clk);
    #1;
    compared++;
    if (error !== 1'b1) begin mismatched++; $display("FAIL short_error: error=%b required 1", error); end
    compared++;
    if (done_cnt != 0) begin mismatched++; $display("FAIL short_done: %0d pulses required 0", done_cnt); end
    compared++;
    if (shift_cycles != TOTAL) begin mismatched++; $display("FAIL short_shifts: %0d required %0d", shift_cycles, TOTAL); end
  endtask

  task automatic test_restart();
    bit ok;
    chain_len_m = 20; tail_zero = 1'b0;
    kick(8'hC3, 8'h5A, 8'hF0);
    #1;
    compared++;
    if (error !== 1'b0) begin mismatched++; $display("FAIL restart_clear: error=%b required 0 after start", error); end
    wait_end(200, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL restart_timeout: no done/error within 200 cycles"); end
    repeat (4) @(negedge prog_clk);
    #1;
    compared++;
    if (done_cnt != 1 || error !== 1'b0) begin
      mismatched++;
      $display("FAIL restart_result: done_cnt=%0d error=%b required 1 and 0", done_cnt, error);
    end
    compared++;
    if (chain[19:0] !== 20'hC35AF) begin mismatched++; $display("FAIL restart_chain: %h required c35af", chain[19:0]); end
  endtask

  task automatic test_tail_zero();
    bit ok;
    chain_len_m = 20; tail_zero = 1'b1;
    kick(8'hC3, 8'h5A, 8'hF0);
    wait_end(200, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL tail0_timeout: no done/error within 200 cycles"); end
    repeat (4) @(negedge prog_clk);
    #1;
    compared++;
    if (error !== 1'b1 || done_cnt != 0) begin
      mismatched++;
      $display("FAIL tail0_result: error=%b done_cnt=%0d required 1 and 0", error, done_cnt);
    end
    compared++;
    if (error_cyc - start_cyc != lat1) begin
      mismatched++;
      $display("FAIL tail0_timing: error after %0d cycles required %0d", error_cyc - start_cyc, lat1);
    end
    compared++;
    if (shift_cycles != TOTAL) begin mismatched++; $display("FAIL tail0_shifts: %0d required %0d", shift_cycles, TOTAL); end
    tail_zero = 1'b0;
  endtask

  task automatic test_start_during_load();
    bit ok;
    int prev;
    int drops;
    chain_len_m = 20; tail_zero = 1'b0;
    kick(8'hC3, 8'h5A, 8'hF0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk);
      #1;
      if (shift_count >= 5'd12) begin ok = 1'b1; break; end
    end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL restart_busy_reach: shift_count=%0d required 12", shift_count); end
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    prev  = int'(shift_count);
    drops = 0;
    ok    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge prog_clk);
      #1;
      if (int'(shift_count) < prev) drops++;
      prev = int'(shift_count);
      if (done_cnt > 0 || error === 1'b1) begin ok = 1'b1; break; end
    end
    compared++;
    if (!ok || drops != 0) begin
      mismatched++;
      $display("FAIL ignore_start: finished=%0d count drops=%0d required 1 and 0", ok, drops);
    end
    repeat (3) @(negedge prog_clk);
    #1;
    compared++;
    if (shift_count !== 5'd28 || done_cnt != 1) begin
      mismatched++;
      $display("FAIL ignore_start_end: shift_count=%0d done_cnt=%0d required 28 and 1", shift_count, done_cnt);
    end
    compared++;
    if (exp_bits.size() != 0) begin mismatched++; $display("FAIL ignore_start_bits: %0d bits unshifted required 0", exp_bits.size()); end
  endtask

  task automatic test_reset_mid_load();
    bit ok;
    chain_len_m = 20; tail_zero = 1'b0;
    kick(8'hC3, 8'h5A, 8'hF0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk);
      #1;
      if (shift_count == 5'd12) begin ok = 1'b1; break; end
    end
    compared++;
    if (!ok) begin mismatched++; $display("FAIL mid_reach: shift_count=%0d required 12", shift_count); end
    #1;
    prog_reset_n = 1'b0;
    #1;
    compared++;
    if ({data_ready, ccff_head, ccff_shift_en, busy, done, error} !== 6'b0 || shift_count !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_async: {rdy,head,sh,busy,done,err}=%b count=%0d required 000000 and 0",
               {data_ready, ccff_head, ccff_shift_en, busy, done, error}, shift_count);
    end
    words.delete();
    exp_bits.delete();
    repeat (2) @(negedge prog_clk);
    prog_reset_n = 1'b1;
    repeat (2) @(negedge prog_clk);
    kick(8'hC3, 8'h5A, 8'hF0);
    wait_end(200, ok);
    compared++;
    if (!ok) begin mismatched++; $display("FAIL mid_timeout: no done/error within 200 cycles"); end
    repeat (4) @(negedge prog_clk);
    #1;
    compared++;
    if (done_cnt != 1 || error !== 1'b0 || shift_cycles != TOTAL) begin
      mismatched++;
      $display("FAIL mid_reload: done_cnt=%0d error=%b shifts=%0d required 1 0 %0d", done_cnt, error, shift_cycles, TOTAL);
    end
    compared++;
    if (chain[19:0] !== 20'hC35AF) begin mismatched++; $display("FAIL mid_chain: %h required c35af", chain[19:0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_short_chain();
    test_restart();
    test_tail_zero();
    test_start_during_load();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
